// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and state type for the write-back stage
package wb_pkg;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_CSR = 2;
    localparam int SRC_MUL = 3;
    localparam int SRC_DIV = 4;
    localparam int SRC_TID = 5;

    localparam int MOP_LB  = 0;
    localparam int MOP_LH  = 1;
    localparam int MOP_LW  = 2;
    localparam int MOP_LBU = 3;
    localparam int MOP_LHU = 4;
    localparam int MOP_W   = 5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - load data lane extraction and sign/zero extension
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]       offset,
    input  logic [XLEN-1:0]  data,
    input  logic [MOP_W-1:0] mem_op,
    output logic [XLEN-1:0]  result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = data[7:0];
            2'd1:    byte_lane = data[15:8];
            2'd2:    byte_lane = data[23:16];
            default: byte_lane = data[31:24];
        endcase
        half_lane = offset[1] ? data[31:16] : data[15:0];
    end

    // Misaligned halfword loads produce zero rather than a straddling value.
    always_comb begin
        result = '0;
        if (mem_op[MOP_LB]) begin
            result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
        end else if (mem_op[MOP_LBU]) begin
            result = {{(XLEN-8){1'b0}}, byte_lane};
        end else if (mem_op[MOP_LH]) begin
            result = offset[0] ? '0 : {{(XLEN-16){half_lane[15]}}, half_lane};
        end else if (mem_op[MOP_LHU]) begin
            result = offset[0] ? '0 : {{(XLEN-16){1'b0}}, half_lane};
        end else if (mem_op[MOP_LW]) begin
            result = data;
        end
    end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage: result select, GR write, exception/ERTN redirect
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NSRC  = 6,
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [4:0]           in_dest,
    input  logic                 in_gr_we,
    input  logic [NSRC-1:0]      in_sel,
    input  logic [NSRC*XLEN-1:0] in_res,
    input  logic [MOP_W-1:0]     in_mem_op,
    input  logic                 in_exc,
    input  logic [5:0]           in_ecode,
    input  logic [8:0]           in_esubcode,
    input  logic [XLEN-1:0]      in_maddr,
    input  logic                 in_ertn,
    input  logic                 flush_ack,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 byp_valid,
    output logic [4:0]           byp_dest,
    output logic [XLEN-1:0]      byp_data,
    output logic                 flush,
    output logic                 exc_submit,
    output logic                 ertn_submit,
    output logic [5:0]           exc_ecode,
    output logic [8:0]           exc_esubcode,
    output logic [XLEN-1:0]      exc_pc,
    output logic [XLEN-1:0]      exc_maddr,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [XLEN-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [4:0]           debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata
);

    wb_state_t       state_q, state_d;
    logic [XLEN-1:0] load_data, sel_res;
    logic            accept, active, redirect;

    logic            ent_valid, ent_gr_we, ent_exc, ent_ertn;
    logic [XLEN-1:0] ent_pc, ent_res, ent_maddr;
    logic [4:0]      ent_dest;
    logic [5:0]      ent_ecode;
    logic [8:0]      ent_esubcode;

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .offset (in_res[1:0]),
        .data   (in_res[SRC_MEM*XLEN +: XLEN]),
        .mem_op (in_mem_op),
        .result (load_data)
    );

    always_comb begin
        sel_res = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (in_sel[i]) begin
                sel_res = (i == SRC_MEM) ? load_data : in_res[i*XLEN +: XLEN];
            end
        end
        if (!$onehot(in_sel)) begin
            sel_res = '0;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;
    assign active   = ent_valid && (state_q == ST_RUN);
    assign redirect = active && (ent_exc || ent_ertn);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (redirect)  state_d = ST_FLUSH;
            ST_FLUSH: if (flush_ack) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // An entry accepted alongside a redirecting one is younger and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            ent_valid    <= 1'b0;
            ent_gr_we    <= 1'b0;
            ent_exc      <= 1'b0;
            ent_ertn     <= 1'b0;
            ent_pc       <= '0;
            ent_res      <= '0;
            ent_maddr    <= '0;
            ent_dest     <= '0;
            ent_ecode    <= '0;
            ent_esubcode <= '0;
            retire_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            ent_valid <= accept && !redirect;
            if (accept) begin
                ent_gr_we    <= in_gr_we;
                ent_exc      <= in_exc;
                ent_ertn     <= in_ertn;
                ent_pc       <= in_pc;
                ent_res      <= sel_res;
                ent_maddr    <= in_maddr;
                ent_dest     <= in_dest;
                ent_ecode    <= in_ecode;
                ent_esubcode <= in_esubcode;
            end
            if (active && !ent_exc) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign rf_we        = active && ent_gr_we && !ent_exc && !ent_ertn && (ent_dest != 5'd0);
    assign rf_waddr     = ent_dest;
    assign rf_wdata     = ent_res;
    assign byp_valid    = rf_we;
    assign byp_dest     = ent_dest;
    assign byp_data     = ent_res;
    assign flush        = redirect || (state_q == ST_FLUSH);
    assign exc_submit   = active && ent_exc;
    assign ertn_submit  = active && ent_ertn && !ent_exc;
    assign exc_ecode    = ent_ecode;
    assign exc_esubcode = ent_esubcode;
    assign exc_pc       = ent_pc;
    assign exc_maddr    = ent_maddr;

    assign debug_wb_pc       = ent_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ent_dest;
    assign debug_wb_rf_wdata = ent_res;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - scoreboard bench for wb_unit
module tb_wb_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_pc = '0;
    logic [4:0]   in_dest = '0;
    logic         in_gr_we = 1'b0;
    logic [5:0]   in_sel = '0;
    logic [191:0] in_res = '0;
    logic [4:0]   in_mem_op = '0;
    logic         in_exc = 1'b0;
    logic [5:0]   in_ecode = '0;
    logic [8:0]   in_esubcode = '0;
    logic [31:0]  in_maddr = '0;
    logic         in_ertn = 1'b0;
    logic         flush_ack = 1'b0;
    logic         rf_we, byp_valid, flush, exc_submit, ertn_submit;
    logic [4:0]   rf_waddr, byp_dest, debug_wb_rf_wnum;
    logic [31:0]  rf_wdata, byp_data, exc_pc, exc_maddr, debug_wb_pc, debug_wb_rf_wdata;
    logic [5:0]   exc_ecode;
    logic [8:0]   exc_esubcode;
    logic [3:0]   retire_cnt, debug_wb_rf_we;

    wb_unit #(.XLEN(32), .NSRC(6), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_dest(in_dest), .in_gr_we(in_gr_we), .in_sel(in_sel),
        .in_res(in_res), .in_mem_op(in_mem_op), .in_exc(in_exc), .in_ecode(in_ecode),
        .in_esubcode(in_esubcode), .in_maddr(in_maddr), .in_ertn(in_ertn),
        .flush_ack(flush_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_data(byp_data), .flush(flush),
        .exc_submit(exc_submit), .ertn_submit(ertn_submit), .exc_ecode(exc_ecode),
        .exc_esubcode(exc_esubcode), .exc_pc(exc_pc), .exc_maddr(exc_maddr),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       nm;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        chk_wd;
        logic        ex;
        logic        er;
        logic        fl;
        logic        rdy;
        logic [3:0]  cnt;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  exp_cnt = '0;
    logic [31:0] pc = 32'h1C00_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    chk({e.nm, " missed cycle"}, 32'(cyc), 32'(e.cyc));
                end else begin
                    chk({e.nm, " rf_we"}, 32'(rf_we), 32'(e.we));
                    chk({e.nm, " byp_valid"}, 32'(byp_valid), 32'(e.we));
                    chk({e.nm, " dbg_we"}, 32'(debug_wb_rf_we), {28'd0, {4{e.we}}});
                    chk({e.nm, " exc_submit"}, 32'(exc_submit), 32'(e.ex));
                    chk({e.nm, " ertn_submit"}, 32'(ertn_submit), 32'(e.er));
                    chk({e.nm, " flush"}, 32'(flush), 32'(e.fl));
                    chk({e.nm, " in_ready"}, 32'(in_ready), 32'(e.rdy));
                    chk({e.nm, " retire_cnt"}, 32'(retire_cnt), 32'(e.cnt));
                    if (e.we) begin
                        chk({e.nm, " waddr"}, 32'(rf_waddr), 32'(e.wa));
                        chk({e.nm, " byp_data"}, byp_data, e.wd);
                    end
                    if (e.chk_wd) chk({e.nm, " wdata"}, rf_wdata, e.wd);
                    if (e.ex) begin
                        chk({e.nm, " ecode"}, 32'(exc_ecode), 32'h9);
                        chk({e.nm, " exc_pc"}, exc_pc, e.pc);
                    end
                end
            end
        end
    end

    task automatic push_status(input string nm, input logic fl, input logic rdy);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.we = 1'b0; e.wa = '0; e.wd = '0; e.chk_wd = 1'b0;
        e.ex = 1'b0; e.er = 1'b0; e.fl = fl; e.rdy = rdy; e.cnt = exp_cnt; e.pc = '0;
        q.push_back(e);
    endtask

    task automatic issue(input string nm, input logic [5:0] sel, input logic [31:0] r0,
                         input logic [31:0] r1, input logic [31:0] r3, input logic [4:0] mop,
                         input logic [4:0] dest, input logic gw, input logic ex, input logic er,
                         input logic ew, input logic [31:0] ewd, input logic cw);
        exp_t e;
        in_valid = 1'b1; in_sel = sel; in_mem_op = mop; in_dest = dest; in_gr_we = gw;
        in_res = {32'h7777_0005, 32'h6666_0004, r3, 32'h5555_0002, r1, r0};
        in_pc = pc; in_exc = ex; in_ertn = er; in_ecode = 6'h9; in_esubcode = 9'h3;
        in_maddr = 32'hA0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_exc = 1'b0; in_ertn = 1'b0;
        e.cyc = cyc; e.nm = nm; e.we = ew; e.wa = dest; e.wd = ewd; e.chk_wd = cw;
        e.ex = ex; e.er = er && !ex; e.fl = ex || er; e.rdy = 1'b1; e.cnt = exp_cnt; e.pc = pc;
        q.push_back(e);
        if (!ex) exp_cnt = exp_cnt + 4'd1;
        pc = pc + 32'd4;
    endtask

    // Offers a probe entry while flushing; it must never reach the GR file.
    task automatic do_flush(input string nm, input int hold);
        @(posedge clk); #1;
        push_status({nm, " hold"}, 1'b1, 1'b0);
        in_valid = 1'b1; in_gr_we = 1'b1; in_dest = 5'd9; in_sel = 6'b000001;
        repeat (hold) begin
            @(posedge clk); #1;
            push_status({nm, " hold"}, 1'b1, 1'b0);
        end
        flush_ack = 1'b1;
        @(posedge clk); #1;
        flush_ack = 1'b0; in_valid = 1'b0;
        push_status({nm, " resume"}, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_status("reset", 1'b0, 1'b1);

        issue("lb",      6'b000010, 32'h1003, 32'h80FF_1234, 32'h0, 5'b00001, 5'd5, 1, 0, 0, 1, 32'hFFFF_FF80, 1);
        issue("lhu",     6'b000010, 32'h2,    32'h9ABC_0000, 32'h0, 5'b10000, 5'd6, 1, 0, 0, 1, 32'h0000_9ABC, 1);
        issue("lh_odd",  6'b000010, 32'h1,    32'h9ABC_0000, 32'h0, 5'b00010, 5'd6, 1, 0, 0, 1, 32'h0, 1);
        issue("lbu",     6'b000010, 32'h1,    32'h0000_8000, 32'h0, 5'b01000, 5'd4, 1, 0, 0, 1, 32'h0000_0080, 1);
        issue("lw",      6'b000010, 32'h0,    32'hDEAD_BEEF, 32'h0, 5'b00100, 5'd4, 1, 0, 0, 1, 32'hDEAD_BEEF, 1);
        issue("mul",     6'b001000, 32'h0,    32'h0,         32'h1234, 5'b0,  5'd7, 1, 0, 0, 1, 32'h1234, 1);
        issue("mul_r0",  6'b001000, 32'h0,    32'h0,         32'h1234, 5'b0,  5'd0, 1, 0, 0, 0, 32'h0, 0);
        issue("multi",   6'b000011, 32'h55,   32'h66,        32'h0, 5'b00100, 5'd8, 1, 0, 0, 1, 32'h0, 1);
        issue("nosel",   6'b000000, 32'h55,   32'h66,        32'h0, 5'b0,     5'd8, 1, 0, 0, 1, 32'h0, 1);
        issue("csr",     6'b000100, 32'h0,    32'h0,         32'h0, 5'b0,     5'd2, 1, 0, 0, 1, 32'h5555_0002, 1);
        issue("no_gwe",  6'b000001, 32'hCAFE, 32'h0,         32'h0, 5'b0,     5'd9, 0, 0, 0, 0, 32'h0, 0);

        issue("ertn",    6'b000001, 32'h1,    32'h0,         32'h0, 5'b0,     5'd3, 1, 0, 1, 0, 32'h0, 0);
        do_flush("ertn", 1);
        issue("exc",     6'b000001, 32'h1,    32'h0,         32'h0, 5'b0,     5'd3, 1, 1, 0, 0, 32'h0, 0);
        do_flush("exc", 3);
        issue("exc_ertn", 6'b000001, 32'h1,   32'h0,         32'h0, 5'b0,     5'd3, 1, 1, 1, 0, 32'h0, 0);
        do_flush("exc_ertn", 0);

        issue("rst_exc", 6'b000001, 32'h1,    32'h0,         32'h0, 5'b0,     5'd3, 1, 1, 0, 0, 32'h0, 0);
        @(posedge clk); #1;
        chk("pre-reset in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset flush", 32'(flush), 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd1);
        chk("async reset retire_cnt", 32'(retire_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = '0;
        push_status("post-reset", 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            issue($sformatf("wrap%0d", i), 6'b000001, 32'(i), 32'h0, 32'h0, 5'b0, 5'd1, 1, 0, 0, 1, 32'(i), 1);
        end
        @(posedge clk); #1;
        push_status("wrap end", 1'b0, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) chk("scoreboard drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NSRC, default 6, result sources; index 0 alu, 1 mem, 2 csr, 3 mul, 4 div, 5 tid.
REQ-003 SHALL have parameter CNT_W, default 64, retire-counter width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  upstream entry valid.
REQ-007 SHALL have port in_ready  out  1  stage accepts entry this cycle.
REQ-008 SHALL have port in_pc  in  XLEN  entry PC.
REQ-009 SHALL have port in_dest  in  5  destination GR.
REQ-010 SHALL have port in_gr_we  in  1  entry writes GR.
REQ-011 SHALL have port in_sel  in  NSRC  one-hot result-source select.
REQ-012 SHALL have port in_res  in  NSRC*XLEN  packed source results, source i at bits [i*XLEN +: XLEN].
REQ-013 SHALL have port in_mem_op  in  5  one-hot {LHU,LBU,LW,LH,LB}, bit0 = LB.
REQ-014 SHALL have port in_exc  in  1  entry carries exception.
REQ-015 SHALL have port in_ecode / in_esubcode / in_maddr  in  6 / 9 / XLEN  exception info.
REQ-016 SHALL have port in_ertn  in  1  entry is ERTN.
REQ-017 SHALL have port flush_ack  in  1  redirect complete, frontend refilled.
REQ-018 SHALL have port rf_we / rf_waddr / rf_wdata  out  1 / 5 / XLEN  GR write port.
REQ-019 SHALL have port byp_valid / byp_dest / byp_data  out  1 / 5 / XLEN  forwarding to ID.
REQ-020 SHALL have port flush  out  1  pipeline flush request.
REQ-021 SHALL have port exc_submit / ertn_submit  out  1 / 1  one-cycle pulses to CSR.
REQ-022 SHALL have port exc_ecode / exc_esubcode / exc_pc / exc_maddr  out  6 / 9 / XLEN / XLEN  exception info to CSR.
REQ-023 SHALL have port retire_cnt  out  CNT_W  retired-instruction count.
REQ-024 SHALL have port debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  XLEN / 4 / 5 / XLEN  trace.

Function
REQ-025 SHALL hold one entry register; entry captured at rising edge when in_valid && in_ready; rf write in following cycle (latency 1).
REQ-026 SHALL implement states RUN and FLUSH; in_ready = (state==RUN); an entry retires in the one cycle it is valid in RUN.
REQ-027 Load data SHALL be extracted from source 1 by in_res[0][1:0]: LB/LBU byte lane, LH/LHU half lane (offset 00/10), LW whole word; LB/LH sign-extend, LBU/LHU zero-extend; LH/LHU at odd offset yields 0.
REQ-028 Final result SHALL be the selected source (mem via REQ-027); in_sel zero or multi-hot yields 0.
REQ-029 rf_we SHALL = entry valid && gr_we && !exc && !ertn && dest!=0; byp_valid identical; byp_data = rf_wdata (covers mul/div).
REQ-030 Entry with exc: exc_submit pulses 1 cycle, exc_* driven from entry, rf_we=0, flush=1, state -> FLUSH; in_ertn without exc: ertn_submit pulses instead; exc and ertn together: exception wins, no ertn_submit.
REQ-031 In FLUSH: flush held 1, in_ready=0, no capture; flush_ack -> RUN next edge; flush_ack in RUN ignored.
REQ-032 retire_cnt SHALL +1 per retired entry without exception (ERTN counts); wraps modulo 2^CNT_W.
REQ-033 debug_wb_rf_we = {4{rf_we}}; debug fields from entry every cycle.

Reset
REQ-034 rst_n low SHALL asynchronously clear entry valid, state to RUN, retire_cnt 0, all pulse/write/flush outputs 0; mid-FLUSH reset returns to RUN without waiting for flush_ack.

Structure
REQ-035 Shared package wb_pkg SHALL hold source indices, mem_op bit positions, state enum; sub-module wb_load_align (XLEN-parametrised, combinational) implements REQ-027.

Verification
REQ-036 LB, res[0]=0x1003, mem=0x80FF_1234, dest 5 -> next cycle rf_we=1, waddr 5, wdata 0xFFFF_FF80.
REQ-037 LHU, offset 2, mem=0x9ABC_0000 -> wdata 0x0000_9ABC; LH offset 1 -> wdata 0.
REQ-038 MUL sel, res[3]=0x1234, dest 7 -> byp_valid=1, byp_data 0x1234; dest 0 -> rf_we=0, byp_valid=0.
REQ-039 exc, ecode 0x9, pc 0x1C00_0100 -> exc_submit 1 cycle, flush=1, in_ready=0 until flush_ack, RUN next cycle, retire_cnt unchanged.
REQ-040 CNT_W=4, retire_cnt=15, retire one -> 0; rst_n low during FLUSH -> state RUN, in_ready=1 after release.
